// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; bytes are pushed on rising edges of start_i.
// tx_o, tx_done_o and busy_o are registered from the current FSM state, so they lag it by one cycle.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   input  logic [7:0] data_i,
   output logic       tx_o,
   output logic       busy_o,
   output logic       tx_done_o,
   output logic       fifo_full_o,
   output logic       overflow_o
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [PW:0]   CNT_FULL  = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          start_prev_q, start_prev_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          tx_done_q, tx_done_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    mem_q [FIFO_DEPTH];

   logic strobe, pop, push, baud_last, fifo_empty, fifo_full;

   always_comb begin
      // NOTE: every signal gets a default first so no path through the block can infer a latch.
      state_d      = state_q;
      baud_d       = baud_q;
      idx_d        = idx_q;
      shreg_d      = shreg_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      start_prev_d = start_i;

      strobe     = start_i & ~start_prev_q;
      fifo_empty = (count_q == '0);
      fifo_full  = (count_q == CNT_FULL);
      baud_last  = (baud_q == BAUD_LAST);
      pop        = (state_q == IDLE) && !fifo_empty;
      // A full FIFO still accepts a byte when the head leaves in the same cycle.
      push       = strobe && (!fifo_full || pop);
      overflow_d = overflow_q | (strobe & ~push);

      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase

      if (state_q != IDLE) baud_d = baud_last ? '0 : baud_q + BW'(1);

      case (state_q)
         IDLE: begin
            if (pop) begin
               shreg_d = mem_q[rd_ptr_q];
               baud_d  = '0;
               state_d = START;
            end
         end
         START: begin
            if (baud_last) begin
               idx_d   = 3'd0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (baud_last) begin
               shreg_d = {1'b0, shreg_q[7:1]};
               if (idx_q == 3'd7) state_d = STOP;
               else               idx_d   = idx_q + 3'd1;
            end
         end
         STOP: begin
            if (baud_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      tx_d      = (state_q == START) ? 1'b0 : (state_q == DATA) ? shreg_q[0] : 1'b1;
      tx_done_d = (state_q == STOP) && baud_last;
      busy_d    = (state_q != IDLE) || !fifo_empty;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         baud_q       <= '0;
         idx_q        <= '0;
         shreg_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         start_prev_q <= 1'b0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         tx_done_q    <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         baud_q       <= baud_d;
         idx_q        <= idx_d;
         shreg_q      <= shreg_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         start_prev_q <= start_prev_d;
         tx_q         <= tx_d;
         busy_q       <= busy_d;
         tx_done_q    <= tx_done_d;
         overflow_q   <= overflow_d;
      end
   end

   // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= data_i;
   end

   assign tx_o        = tx_q;
   assign busy_o      = busy_q;
   assign tx_done_o   = tx_done_q;
   assign fifo_full_o = fifo_full;
   assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A negedge line monitor decodes frames independently of the design's internals.
module tb_uart_tx_fifo;

   localparam int C = 4;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_i = 1'b0;
   logic [7:0] data_i = 8'h00;
   logic       tx_o, busy_o, tx_done_o, fifo_full_o, overflow_o;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int done_cnt = 0;
   int rx_err = 0;
   logic [7:0] rx_q[$];
   int         fall_q[$];
   bit         mon_active = 1'b0;
   int         mon_t = 0;
   logic [7:0] mon_sh = 8'h00;
   int         d0;
   bit         low_seen;

   uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .data_i      (data_i),
      .tx_o        (tx_o),
      .busy_o      (busy_o),
      .tx_done_o   (tx_done_o),
      .fifo_full_o (fifo_full_o),
      .overflow_o  (overflow_o)
   );

   initial forever #5 clk = ~clk;

   // Line receiver: samples each bit at its centre, relative to the first low cycle of the start bit.
   initial begin : rx_mon
      forever begin
         @(negedge clk);
         cyc++;
         if (tx_done_o === 1'b1) done_cnt++;
         if (rst) begin
            mon_active = 1'b0;
         end else if (!mon_active) begin
            if (tx_o === 1'b0) begin
               mon_active = 1'b1;
               mon_t = 0;
               fall_q.push_back(cyc);
            end
         end else begin
            mon_t++;
            if (mon_t >= C && mon_t < 9*C && (mon_t % C) == C/2) mon_sh = {tx_o, mon_sh[7:1]};
            if (mon_t == 9*C + C/2) begin
               if (tx_o !== 1'b1) rx_err++;
               rx_q.push_back(mon_sh);
               mon_active = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rx_at(input int i);
      if (i < rx_q.size()) return rx_q[i];
      return 8'hxx;
   endfunction

   function automatic int fall_at(input int i);
      if (i < fall_q.size()) return fall_q[i];
      return -1000;
   endfunction

   // Called on the first start-bit cycle; returns on the final stop-bit cycle.
   task automatic frame_check(input logic [7:0] b, input string tag);
      for (int i = 0; i < 10*C; i++) begin
         int  k;
         logic exp_tx;
         k = i / C;
         exp_tx = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
         check($sformatf("%s_tx_c%0d", tag, i), tx_o, exp_tx);
         check($sformatf("%s_done_c%0d", tag, i), tx_done_o, (i == 10*C-1));
         if (i < 10*C-1) tick();
      end
   endtask

   task automatic wait_idle(input int max_cycles, input string tag);
      int n;
      n = 0;
      while (busy_o !== 1'b0 && n < max_cycles) begin
         tick();
         n++;
      end
      check(tag, busy_o, 1'b0);
   endtask

   task automatic clear_mon();
      rx_q.delete();
      fall_q.delete();
      rx_err = 0;
      d0 = done_cnt;
   endtask

   initial begin
      // Reset held three cycles with start_i low.
      #1;
      repeat (3) tick();
      check("rst_tx", tx_o, 1'b1);
      check("rst_busy", busy_o, 1'b0);
      check("rst_done", tx_done_o, 1'b0);
      check("rst_full", fifo_full_o, 1'b0);
      check("rst_ovf", overflow_o, 1'b0);
      rst = 1'b0;
      repeat (20) tick();
      check("idle_tx", tx_o, 1'b1);
      check("idle_busy", busy_o, 1'b0);
      check("idle_done", tx_done_o, 1'b0);
      check("idle_full", fifo_full_o, 1'b0);
      check("idle_ovf", overflow_o, 1'b0);

      // Single byte 0xA5: exact latency and bit-by-bit frame.
      clear_mon();
      start_i = 1'b1; data_i = 8'hA5;
      tick();
      check("a5_n_tx", tx_o, 1'b1);
      check("a5_n_busy", busy_o, 1'b0);
      start_i = 1'b0;
      tick();
      check("a5_n1_tx", tx_o, 1'b1);
      check("a5_n1_busy", busy_o, 1'b1);
      tick();
      frame_check(8'hA5, "a5");
      check("a5_last_busy", busy_o, 1'b1);
      tick();
      check("a5_after_tx", tx_o, 1'b1);
      check("a5_after_busy", busy_o, 1'b0);
      check("a5_after_done", tx_done_o, 1'b0);
      check("a5_rx_cnt", rx_q.size(), 1);
      check("a5_rx_byte", rx_at(0), 8'hA5);
      check("a5_done_cnt", done_cnt - d0, 1);

      // Level held high for 200 cycles gives a single frame.
      clear_mon();
      start_i = 1'b1; data_i = 8'h3C;
      tick();
      tick();
      tick();
      frame_check(8'h3C, "hold");
      repeat (159) tick();
      start_i = 1'b0;
      repeat (60) tick();
      check("hold_rx_cnt", rx_q.size(), 1);
      check("hold_rx_byte", rx_at(0), 8'h3C);
      check("hold_falls", fall_q.size(), 1);
      check("hold_done_cnt", done_cnt - d0, 1);
      check("hold_ovf", overflow_o, 1'b0);
      check("hold_busy", busy_o, 1'b0);

      // Six strobes two cycles apart: 0x01 popped at once, 0x02-0x05 fill, 0x06 dropped.
      clear_mon();
      for (int k = 1; k <= 6; k++) begin
         start_i = 1'b1; data_i = 8'(k);
         tick();
         if (k == 4) check("ovf_full_k4", fifo_full_o, 1'b0);
         if (k == 5) begin
            check("ovf_full_k5", fifo_full_o, 1'b1);
            check("ovf_ovf_k5", overflow_o, 1'b0);
         end
         if (k == 6) begin
            check("ovf_full_k6", fifo_full_o, 1'b1);
            check("ovf_ovf_k6", overflow_o, 1'b1);
         end
         start_i = 1'b0;
         tick();
      end
      wait_idle(400, "ovf_idle");
      check("ovf_rx_cnt", rx_q.size(), 5);
      for (int i = 0; i < 5; i++) check($sformatf("ovf_rx_%0d", i), rx_at(i), 8'(i + 1));
      for (int i = 0; i < 4; i++) check($sformatf("ovf_gap_%0d", i), fall_at(i+1) - fall_at(i), 10*C + 1);
      check("ovf_sticky", overflow_o, 1'b1);
      check("ovf_full_end", fifo_full_o, 1'b0);
      check("ovf_done_cnt", done_cnt - d0, 5);
      check("ovf_rx_err", rx_err, 0);

      // Reset clears the sticky flag; then a strobe lands on the pop cycle of a full FIFO.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("pp_ovf_cleared", overflow_o, 1'b0);
      clear_mon();
      start_i = 1'b1; data_i = 8'h11;
      tick();
      start_i = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
         start_i = 1'b1; data_i = 8'(8'h12 + k);
         tick();
         start_i = 1'b0;
         tick();
      end
      check("pp_full", fifo_full_o, 1'b1);
      repeat (32) tick();
      check("pp_sync_done", tx_done_o, 1'b1);
      start_i = 1'b1; data_i = 8'h16;
      tick();
      start_i = 1'b0;
      check("pp_full_kept", fifo_full_o, 1'b1);
      check("pp_ovf", overflow_o, 1'b0);
      wait_idle(400, "pp_idle");
      check("pp_rx_cnt", rx_q.size(), 6);
      for (int i = 0; i < 6; i++) check($sformatf("pp_rx_%0d", i), rx_at(i), 8'(8'h11 + i));
      check("pp_ovf_end", overflow_o, 1'b0);

      // Reset during data bit 3 of 0x21 with 0x22, 0x23 queued.
      clear_mon();
      start_i = 1'b1; data_i = 8'h21;
      tick();
      start_i = 1'b0;
      tick();
      start_i = 1'b1; data_i = 8'h22;
      tick();
      start_i = 1'b0;
      tick();
      start_i = 1'b1; data_i = 8'h23;
      tick();
      start_i = 1'b0;
      repeat (14) tick();
      check("mid_bit3_tx", tx_o, 1'b0);
      check("mid_busy", busy_o, 1'b1);
      rst = 1'b1;
      tick();
      check("mid_rst_tx", tx_o, 1'b1);
      check("mid_rst_busy", busy_o, 1'b0);
      check("mid_rst_done", tx_done_o, 1'b0);
      check("mid_rst_full", fifo_full_o, 1'b0);
      check("mid_rst_ovf", overflow_o, 1'b0);
      rst = 1'b0;
      low_seen = 1'b0;
      repeat (100) begin
         tick();
         if (tx_o !== 1'b1) low_seen = 1'b1;
      end
      check("mid_no_tx", low_seen, 1'b0);
      check("mid_no_done", done_cnt - d0, 0);
      check("mid_busy_end", busy_o, 1'b0);
      check("mid_falls", fall_q.size(), 1);
      check("mid_rx_cnt", rx_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
